// File: rtl/cpu_pkg.sv
// Shared types for the write-back stage: data word, register address,
// pending-write queue entry and the halt sequencing states.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREG   = 16;
  localparam int unsigned REG_AW = 4;

  typedef logic [DATA_W-1:0] block;
  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t addr;
    block      data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    HALT_RUN,
    HALT_DRAIN,
    HALT_DONE
  } halt_state_e;

  function automatic wb_entry_t make_entry(input reg_addr_t addr, input block data);
    wb_entry_t e;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/wb_queue.sv
// Pending-write FIFO: entry 0 is always the head (oldest). Up to two
// pushes and one pop per cycle; all entries are exposed for searching.
module wb_queue
  import cpu_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_pop,
  input  logic                           i_push0,
  input  wb_entry_t                      i_push0_entry,
  input  logic                           i_push1,
  input  wb_entry_t                      i_push1_entry,
  output logic [$clog2(QDEPTH+1)-1:0]    o_count,
  output wb_entry_t                      o_entries [QDEPTH]
);

  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  wb_entry_t        r_ent [QDEPTH];
  wb_entry_t        w_ent [QDEPTH];
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt;

  // Pop shifts everything down first, then pushes append at the new tail
  // in order (push0 older than push1).
  always_comb begin
    w_ent = r_ent;
    w_cnt = r_cnt;
    if (i_pop) begin
      for (int unsigned i = 0; i + 1 < QDEPTH; i++) begin
        w_ent[i] = r_ent[i+1];
      end
      w_ent[QDEPTH-1] = '0;
      w_cnt = r_cnt - 1'b1;
    end
    if (i_push0) begin
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        if (CNT_W'(i) == w_cnt) w_ent[i] = i_push0_entry;
      end
      w_cnt = w_cnt + 1'b1;
    end
    if (i_push1) begin
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        if (CNT_W'(i) == w_cnt) w_ent[i] = i_push1_entry;
      end
      w_cnt = w_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        r_ent[i] <= '0;
      end
      r_cnt <= '0;
    end else begin
      r_ent <= w_ent;
      r_cnt <= w_cnt;
    end
  end

  assign o_count   = r_cnt;
  assign o_entries = r_ent;

endmodule

// File: rtl/reg_writeback.sv
// Write-back stage and register file: serialises mem/exe writes in program
// order through wb_queue. Optional read bypass under `REG_BYPASS_EN.
module reg_writeback
  import cpu_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_wr_en,
  input  logic [3:0]        mem_wr_addr,
  input  logic [DATA_W-1:0] mem_wr_data,
  input  logic              exe_wr_en,
  input  logic [3:0]        exe_wr_addr,
  input  logic [DATA_W-1:0] exe_wr_data,
  input  logic [3:0]        rd_addr1,
  input  logic [3:0]        rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              do_halt,
  output logic              stall,
  output logic              halted,
  output logic              overflow_err
);

  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  block             r_regs [NREG];
  halt_state_e      r_halt_state;
  halt_state_e      w_halt_next;
  logic             r_ovf;

  logic [CNT_W-1:0] w_count;
  wb_entry_t        w_entries [QDEPTH];
  logic             w_stall;
  logic             w_head_vld;
  logic             w_mem_acc;
  logic             w_exe_acc;
  wb_entry_t        w_mem_ent;
  wb_entry_t        w_exe_ent;
  logic             w_rf_we;
  wb_entry_t        w_rf_ent;
  logic             w_push0;
  wb_entry_t        w_push0_ent;
  logic             w_push1;
  wb_entry_t        w_push1_ent;

  assign w_stall    = (w_count == CNT_W'(QDEPTH));
  assign w_head_vld = (w_count != '0);
  assign w_mem_acc  = mem_wr_en && !w_stall && (r_halt_state != HALT_DONE);
  assign w_exe_acc  = exe_wr_en && !w_stall && (r_halt_state != HALT_DONE);
  assign w_mem_ent  = make_entry(mem_wr_addr, mem_wr_data);
  assign w_exe_ent  = make_entry(exe_wr_addr, exe_wr_data);

  // Oldest candidate (head, then mem, then exe) goes to the array; the
  // rest are pushed in the same relative order.
  always_comb begin
    w_rf_we     = 1'b0;
    w_rf_ent    = '0;
    w_push0     = 1'b0;
    w_push0_ent = '0;
    w_push1     = 1'b0;
    w_push1_ent = '0;
    if (w_head_vld) begin
      w_rf_we  = 1'b1;
      w_rf_ent = w_entries[0];
      if (w_mem_acc) begin
        w_push0     = 1'b1;
        w_push0_ent = w_mem_ent;
        w_push1     = w_exe_acc;
        w_push1_ent = w_exe_ent;
      end else begin
        w_push0     = w_exe_acc;
        w_push0_ent = w_exe_ent;
      end
    end else if (w_mem_acc) begin
      w_rf_we     = 1'b1;
      w_rf_ent    = w_mem_ent;
      w_push0     = w_exe_acc;
      w_push0_ent = w_exe_ent;
    end else if (w_exe_acc) begin
      w_rf_we  = 1'b1;
      w_rf_ent = w_exe_ent;
    end
  end

  wb_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk           (clk),
    .rst           (rst),
    .i_pop         (w_head_vld),
    .i_push0       (w_push0),
    .i_push0_entry (w_push0_ent),
    .i_push1       (w_push1),
    .i_push1_entry (w_push1_ent),
    .o_count       (w_count),
    .o_entries     (w_entries)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_rf_we) begin
      r_regs[w_rf_ent.addr] <= w_rf_ent.data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_halt_state <= HALT_RUN;
      r_ovf        <= 1'b0;
    end else begin
      r_halt_state <= w_halt_next;
      r_ovf        <= r_ovf | (w_stall && (mem_wr_en || exe_wr_en));
    end
  end

  always_comb begin
    w_halt_next = r_halt_state;
    case (r_halt_state)
      HALT_RUN: begin
        if (do_halt) w_halt_next = HALT_DRAIN;
      end
      HALT_DRAIN: begin
        if (!w_head_vld && !mem_wr_en && !exe_wr_en) w_halt_next = HALT_DONE;
      end
      HALT_DONE: w_halt_next = HALT_DONE;
      default:   w_halt_next = HALT_RUN;
    endcase
  end

`ifdef REG_BYPASS_EN
  // Later matches overwrite earlier ones, so the youngest pending value wins.
  function automatic block read_port(input reg_addr_t a);
    block v;
    v = r_regs[a];
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      if (CNT_W'(i) < w_count && w_entries[i].addr == a) v = w_entries[i].data;
    end
    if (w_mem_acc && mem_wr_addr == a) v = mem_wr_data;
    if (w_exe_acc && exe_wr_addr == a) v = exe_wr_data;
    return v;
  endfunction

  always_comb begin
    rd_data1 = read_port(rd_addr1);
    rd_data2 = read_port(rd_addr2);
  end
`else
  always_comb begin
    rd_data1 = r_regs[rd_addr1];
    rd_data2 = r_regs[rd_addr2];
  end
`endif

  assign stall        = w_stall;
  assign halted       = (r_halt_state == HALT_DONE);
  assign overflow_err = r_ovf;

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-back stage and architectural register file for the pipelined core. It accepts register writes from two producers: load results from the memory stage (`do_mem_reg_write` / `mem_value` / `mem_reg_addr`) and ALU results forwarded from execute. It serialises them onto a single register-file write port in program order, using a small pending-write queue, and serves two read ports to decode. It raises `stall` when the queue cannot absorb more writes, and reports `halted` once all writes have drained after `do_halt`.

## Interface
- `DATA_W`, 16, register and data width (`block`)
- `NREG`, 16, number of architectural registers (address width 4)
- `QDEPTH`, 2, pending-write queue entries (≥2)

- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `mem_wr_en`  in  1  load write request (from memory stage `do_mem_reg_write`)
- `mem_wr_addr`  in  4  load destination register
- `mem_wr_data`  in  DATA_W  load data (`mem_value`)
- `exe_wr_en`  in  1  ALU write request
- `exe_wr_addr`  in  4  ALU destination register
- `exe_wr_data`  in  DATA_W  ALU result
- `rd_addr1`, `rd_addr2`  in  4  decode read addresses
- `rd_data1`, `rd_data2`  out  DATA_W  combinational read data
- `do_halt`  in  1  halt request from the pipeline
- `stall`  out  1  queue full; upstream must hold writes
- `halted`  out  1  sticky: halt requested and all writes retired
- `overflow_err`  out  1  sticky: a write arrived while `stall` was high

## Operation
- Program order per cycle: queue head (oldest), then the mem request, then the exe request. The mem request is older than an exe request in the same cycle.
- Each cycle, exactly one candidate, the oldest present, writes the register file. All remaining valid candidates are pushed into the queue, preserving order.
- `stall` = (count == QDEPTH). It is derived from registered state, with no combinational path from inputs.
- While `stall` is high:
  - Both write inputs are ignored.
  - Any asserted `*_wr_en` sets `overflow_err`.
- Count rules:
  - At most +1 net per cycle: 2 arrive, 1 retires.
  - A queue at QDEPTH−1 receiving two writes reaches QDEPTH and never overflows.
- Same-address writes in one cycle: the younger value wins, because it is written or queued later.
- All NREG registers are writable; there is no hardwired zero register.
- Reads return register array contents only, with no bypass (see Configuration).
- Halt:
  - A `do_halt` pulse sets an internal `halt_req`.
  - `halted` rises once `halt_req`, queue empty, and no write input valid all hold at a clock edge.
  - After `halted`, all write inputs are ignored without setting `overflow_err`.
- Reset:
  - Clears every register to 0 and empties the queue.
  - Clears `stall`, `halted`, `overflow_err` and `halt_req` to 0.
  - Reset mid-drain discards all pending writes.

## Timing
- Unqueued write: data is visible on `rd_data*` in the cycle after the request edge, which is one-cycle latency.
- A queued write retires k cycles later, where k is its position in the queue plus one.
- `stall` asserts in the cycle after the push that fills the queue. It deasserts in the cycle after the retire that frees an entry with no new arrival.
- `halted` asserts one cycle after the drain-complete edge.
- Read ports are purely combinational from the address and current state.

## Configuration
- `REG_BYPASS_EN` defined: each read port returns the youngest pending value for its address, searching in this order:
  - `exe_wr_*` input
  - `mem_wr_*` input
  - queue tail → head
  - register array

  Inputs are only considered when `stall` and `halted` are both low.
- `REG_BYPASS_EN` undefined: reads see the array only. The pipeline must rely on its own hazard stalls.

## Structure
- Shared package `cpu_pkg`:
  - `block` (logic [DATA_W-1:0])
  - `reg_addr_t` (logic [3:0])
  - `wb_entry_t` struct {addr, data}
  - the constant `NREG`
- Sub-module `wb_queue`:
  - QDEPTH-entry FIFO of `wb_entry_t`.
  - Up to two pushes and one pop per cycle.
  - Exposes count and all entries, so the bypass logic can search them.

## Test plan
- Reset, then `mem_wr_en`, addr 3, data 0x1234 → `rd_data1` (addr 3) = 0x1234 next cycle; `stall` stays 0.
- Same cycle: mem(r5=0x0A) and exe(r6=0x0B) → r5 written at edge 1, r6 at edge 2; `stall` = 0 throughout with QDEPTH=2.
- Same-address conflict: mem(r2=0x11) with exe(r2=0x22) → r2 = 0x22 after 2 cycles and never ends as 0x11.
- Three consecutive dual-write cycles → `stall` high in cycle 3. A write forced during stall sets `overflow_err` and the forced value is never written. The queue then drains in order.
- `do_halt` with 2 queued writes → `halted` rises exactly one cycle after the last retire. A later write is ignored; `overflow_err` stays unchanged.
- With `REG_BYPASS_EN`: queue holds r4=0x7 and exe presents r4=0x9 → `rd_data2` (addr 4) = 0x9 that cycle. Without the macro, it reads the old array value.
